clkmgr_seq: RTL and testbench
=============================

Name: clkmgr_seq

Overview:
- Reset and lock sequencer for the clkmgra MMCM wrapper. Runs on the free-running input clock.
- Drives the MMCM RESET, qualifies LOCKED, and releases per-output-clock domain resets in a fixed staggered order.
- On lock loss or timeout it retries the MMCM reset, up to a configured limit.
- Sits between the board clock buffer and the clkmgra instance. Each consumer domain re-synchronises its DOMAIN_RESET bit locally.

Parameters:
- RST_CYCLES, 16: cycles MMCM_RESET is held high per attempt (>=1).
- LOCK_STABLE, 64: consecutive synchronised LOCKED=1 cycles required to declare lock (>=1).
- LOCK_TIMEOUT, 100000: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRY, 3: retries after the first attempt before FAIL.
- NUM_DOMAINS, 5: number of domain resets (one per CLKOUTn).
- RELEASE_GAP, 8: cycles between successive domain reset releases (>=1).

Ports:
- CLK_IN  input  1  free-running input clock (same net that feeds clkmgra CLK_IN).
- RESET  input  1  asynchronous, active-high reset.
- LOCKED  input  1  clkmgra LOCKED; asynchronous, 2-flop synchronised internally.
- RESTART  input  1  single-cycle software request for a full re-sequence.
- MMCM_RESET  output  1  to clkmgra RESET, active-high.
- DOMAIN_RESET  output  NUM_DOMAINS  active-high; bit n belongs to CLKOUTn.
- READY  output  1  high only in RUN.
- FAIL  output  1  high only in FAIL.
- RETRY_CNT  output  8  retries in the current sequence, saturating.
- LOSS_CNT  output  8  lock-loss events since RESET, saturating at 255.
- STATE  output  3  encoded FSM state, for debug.

Behaviour:
- Reset values: MMCM_RESET=1, DOMAIN_RESET=all 1, READY=0, FAIL=0, RETRY_CNT=0, LOSS_CNT=0, state=RST (STATE=0), sync flops=0.
- All outputs are registered.
- lk = LOCKED after the 2-flop synchroniser, giving 2 cycles of latency.
- RST (0):
  - MMCM_RESET=1 and DOMAIN_RESET=all 1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - MMCM_RESET falls on the first WAIT_LOCK cycle.
- WAIT_LOCK (1):
  - stable counter increments while lk=1 and clears whenever lk=0 (a glitch is not a retry).
  - timeout counter increments every cycle.
  - When stable reaches LOCK_STABLE, go to RELEASE. The timeout counter is ignored in that cycle.
  - Otherwise, when timeout reaches LOCK_TIMEOUT:
    - if RETRY_CNT < MAX_RETRY, increment RETRY_CNT and go to RST;
    - else go to FAIL.
- RELEASE (2):
  - DOMAIN_RESET[0] clears on the first RELEASE cycle.
  - DOMAIN_RESET[k] clears k*RELEASE_GAP cycles later (bit order 0 to NUM_DOMAINS-1).
  - Bits are never released out of order.
  - After bit NUM_DOMAINS-1 clears, go to RUN. READY=1 on the next cycle, and RETRY_CNT clears to 0 at the same time.
- RUN (3): holds while lk=1.
- Lock loss (lk=0 in RELEASE or RUN):
  - next cycle: DOMAIN_RESET=all 1 and READY=0;
  - LOSS_CNT increments (saturating);
  - go to RST;
  - RETRY_CNT is untouched.
- FAIL (4):
  - MMCM_RESET=1, DOMAIN_RESET=all 1, FAIL=1.
  - Exit only via RESET or RESTART.
- RESTART:
  - in any state, the next state is RST with all outputs forced as on RST entry and RETRY_CNT=0.
  - LOSS_CNT is not changed.
  - RESTART has priority over lock loss and timeout in the same cycle. Lock loss coinciding with RESTART does not increment LOSS_CNT.
  - RESTART during RST restarts the RST_CYCLES count.
- Asynchronous RESET mid-operation:
  - immediately forces the reset values listed above, including MMCM_RESET=1 and DOMAIN_RESET=all 1;
  - the sequence resumes at RST after deassertion.
- Counter widths: $clog2 of each parameter maximum + 1. No wrap in any counter; saturating counters hold at their maximum.

Decomposition:
- Shared package clkmgr_pkg:
  - state encoding localparams ST_RST=0, ST_WAIT_LOCK=1, ST_RELEASE=2, ST_RUN=3, ST_FAIL=4;
  - the 8-bit width of RETRY_CNT/LOSS_CNT.
- One natural sub-module: clkmgr_sync2, a 2-flop synchroniser with async active-high reset, used for LOCKED.
- FSM, counters and release shifter all live in clkmgr_seq.

Test Plan:
- Bench parameters for all scenarios: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2, NUM_DOMAINS=5, RELEASE_GAP=3.
1. Nominal bring-up:
   - Stimulus: release RESET; LOCKED rises 10 cycles after MMCM_RESET falls.
   - Required: MMCM_RESET high for exactly 4 cycles; DOMAIN_RESET bits clear at 3-cycle spacing in order 0..4; READY=1 one cycle after bit 4 clears; RETRY_CNT=0.
2. Lock glitch:
   - Stimulus: in WAIT_LOCK, LOCKED high for 5 cycles, low 1 cycle, then high.
   - Required: RELEASE entered only after 8 further stable synchronised cycles; RETRY_CNT=0.
3. Timeout to FAIL:
   - Stimulus: hold LOCKED=0.
   - Required: 3 RST pulses (RETRY_CNT 0, 1, 2); FAIL=1 after the third timeout; DOMAIN_RESET stays all 1.
   - Then RESTART: back in RST, FAIL=0, RETRY_CNT=0.
4. Lock loss in RUN:
   - Stimulus: drop LOCKED.
   - Required: DOMAIN_RESET=1F and READY=0 within 3 cycles of the drop; LOSS_CNT=1; a fresh 4-cycle MMCM_RESET follows; re-lock gives READY=1 again.
5. Lock loss mid-RELEASE:
   - Stimulus: drop LOCKED after bits 0 and 1 have cleared.
   - Required: all bits reasserted; LOSS_CNT increments; bits 2..4 were never released.
6. Async RESET and simultaneous events:
   - Stimulus: assert RESET mid-RELEASE.
   - Required: outputs equal reset values with no clock edge needed.
   - Stimulus: RESTART and lock loss in the same cycle.
   - Required: LOSS_CNT unchanged.

Source files
------------

// File: rtl/clkmgr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clkmgr_pkg                                             |
// | Description : Shared state encoding, counter width and helpers for   |
// |               the clkmgra reset/lock sequencer.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package clkmgr_pkg;

    // Width of the RETRY_CNT / LOSS_CNT status counters.
    localparam int c_CNT_W = 8;

    // Debug-visible state encoding; these values appear on STATE.
    localparam logic [2:0] ST_RST       = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    typedef enum logic [2:0] {
        S_RST       = ST_RST,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_RELEASE   = ST_RELEASE,
        S_RUN       = ST_RUN,
        S_FAIL      = ST_FAIL
    } state_t;

    // Status counters stick at all-ones instead of wrapping.
    function automatic logic [c_CNT_W-1:0] sat_inc(input logic [c_CNT_W-1:0] v);
        return (v == '1) ? v : v + c_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkmgr_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clkmgr_seq_if                                          |
// | Description : Control/status bundle between the sequencer and the    |
// |               MMCM wrapper / domain consumers.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface clkmgr_seq_if #(
    parameter int NUM_DOMAINS = 5
);
    import clkmgr_pkg::*;

    logic                   locked;
    logic                   restart;
    logic                   mmcm_reset;
    logic [NUM_DOMAINS-1:0] domain_reset;
    logic                   ready;
    logic                   fail;
    logic [c_CNT_W-1:0]     retry_cnt;
    logic [c_CNT_W-1:0]     loss_cnt;
    logic [2:0]             state;

    // Sequencer side.
    modport slave (
        input  locked, restart,
        output mmcm_reset, domain_reset, ready, fail, retry_cnt, loss_cnt, state
    );

    // Environment side: MMCM wrapper, software and consumers.
    modport master (
        output locked, restart,
        input  mmcm_reset, domain_reset, ready, fail, retry_cnt, loss_cnt, state
    );

endinterface
`default_nettype wire

// File: rtl/clkmgr_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clkmgr_sync2                                           |
// | Description : Two-flop synchroniser with async active-high reset.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module clkmgr_sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [1:0] r_sync;

    // Shift the asynchronous input through two flops; output is the second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/clkmgr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clkmgr_seq                                             |
// | Description : MMCM reset/lock sequencer: pulses MMCM reset, qualifies|
// |               LOCKED, releases domain resets in staggered order and  |
// |               retries on timeout or lock loss.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module clkmgr_seq
    import clkmgr_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int MAX_RETRY    = 3,
    parameter int NUM_DOMAINS  = 5,
    parameter int RELEASE_GAP  = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    clkmgr_seq_if.slave   bus
);

    localparam int c_RST_W = $clog2(RST_CYCLES + 1);
    localparam int c_STB_W = $clog2(LOCK_STABLE + 1);
    localparam int c_TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_GAP_W = $clog2(RELEASE_GAP + 1);

    localparam logic [c_RST_W-1:0]     c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_STB_W-1:0]     c_STB_MAX   = c_STB_W'(LOCK_STABLE);
    localparam logic [c_TO_W-1:0]      c_TO_MAX    = c_TO_W'(LOCK_TIMEOUT);
    localparam logic [c_GAP_W-1:0]     c_GAP_LAST  = c_GAP_W'(RELEASE_GAP - 1);
    localparam logic [c_CNT_W-1:0]     c_RETRY_MAX = c_CNT_W'(MAX_RETRY);
    // Release pattern on the first RELEASE cycle: only bit 0 cleared.
    localparam logic [NUM_DOMAINS-1:0] c_DR_FIRST  = ~(NUM_DOMAINS'(1));

    state_t                 r_state, w_state_nxt;
    logic [c_RST_W-1:0]     r_rst_cnt, w_rst_cnt_nxt;
    logic [c_STB_W-1:0]     r_stable, w_stable_nxt;
    logic [c_TO_W-1:0]      r_timeout, w_timeout_nxt;
    logic [c_GAP_W-1:0]     r_gap, w_gap_nxt;
    logic [NUM_DOMAINS-1:0] r_dr, w_dr_nxt;
    logic [c_CNT_W-1:0]     r_retry, w_retry_nxt;
    logic [c_CNT_W-1:0]     r_loss, w_loss_nxt;
    logic                   r_mmcm_reset, r_ready, r_fail;
    logic                   w_lk;

    clkmgr_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.locked),
        .o_q (w_lk)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counters and release shifter; counters clear unless a state advances them.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = '0;
        w_stable_nxt  = '0;
        w_timeout_nxt = '0;
        w_gap_nxt     = '0;
        w_dr_nxt      = r_dr;
        w_retry_nxt   = r_retry;
        w_loss_nxt    = r_loss;

        if (bus.restart) begin
            // Restart outranks lock loss and timeout, and is never counted as a loss.
            w_state_nxt = S_RST;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                S_RST: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + c_RST_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lk && (r_stable != c_STB_MAX)) begin
                        w_stable_nxt = r_stable + c_STB_W'(1);
                    end else if (w_lk) begin
                        w_stable_nxt = r_stable;
                    end
                    w_timeout_nxt = (r_timeout == c_TO_MAX) ? r_timeout : r_timeout + c_TO_W'(1);
                    if (w_lk && (w_stable_nxt == c_STB_MAX)) begin
                        w_state_nxt = S_RELEASE;
                        w_dr_nxt    = c_DR_FIRST;
                    end else if (w_timeout_nxt == c_TO_MAX) begin
                        if (r_retry < c_RETRY_MAX) begin
                            w_retry_nxt = sat_inc(r_retry);
                            w_state_nxt = S_RST;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!w_lk) begin
                        w_state_nxt = S_RST;
                        w_loss_nxt  = sat_inc(r_loss);
                    end else if (r_dr == '0) begin
                        w_state_nxt = S_RUN;
                        w_retry_nxt = '0;
                    end else if (r_gap == c_GAP_LAST) begin
                        // Shifting left clears the next-higher bit, so release stays in order.
                        w_dr_nxt = r_dr << 1;
                    end else begin
                        w_gap_nxt = r_gap + c_GAP_W'(1);
                    end
                end
                S_RUN: begin
                    if (!w_lk) begin
                        w_state_nxt = S_RST;
                        w_loss_nxt  = sat_inc(r_loss);
                    end
                end
                S_FAIL: begin
                    w_state_nxt = S_FAIL;
                end
                default: begin
                    w_state_nxt = S_RST;
                end
            endcase
        end

        // Every domain is held in reset outside RELEASE and RUN.
        if ((w_state_nxt != S_RELEASE) && (w_state_nxt != S_RUN)) begin
            w_dr_nxt = '1;
        end
    end

    // Counters and registered outputs, the latter decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt    <= '0;
            r_stable     <= '0;
            r_timeout    <= '0;
            r_gap        <= '0;
            r_dr         <= '1;
            r_retry      <= '0;
            r_loss       <= '0;
            r_mmcm_reset <= 1'b1;
            r_ready      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_stable     <= w_stable_nxt;
            r_timeout    <= w_timeout_nxt;
            r_gap        <= w_gap_nxt;
            r_dr         <= w_dr_nxt;
            r_retry      <= w_retry_nxt;
            r_loss       <= w_loss_nxt;
            r_mmcm_reset <= (w_state_nxt == S_RST) || (w_state_nxt == S_FAIL);
            r_ready      <= (w_state_nxt == S_RUN);
            r_fail       <= (w_state_nxt == S_FAIL);
        end
    end

    assign bus.mmcm_reset   = r_mmcm_reset;
    assign bus.domain_reset = r_dr;
    assign bus.ready        = r_ready;
    assign bus.fail         = r_fail;
    assign bus.retry_cnt    = r_retry;
    assign bus.loss_cnt     = r_loss;
    assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clkmgr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_clkmgr_seq                                          |
// | Description : Directed self-checking bench for clkmgr_seq with a     |
// |               scoreboard of expected DOMAIN_RESET transitions.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_clkmgr_seq;
    import clkmgr_pkg::*;

    localparam int c_RST_CYCLES   = 4;
    localparam int c_LOCK_STABLE  = 8;
    localparam int c_LOCK_TIMEOUT = 64;
    localparam int c_MAX_RETRY    = 2;
    localparam int c_NUM_DOMAINS  = 5;
    localparam int c_RELEASE_GAP  = 3;

    typedef struct {
        logic [4:0] dr;
        int         gap;   // cycles since previous change, -1 = don't care
    } dr_exp_t;

    logic      clk = 1'b0;
    logic      rst;
    int        cyc = 0;
    int        n_checks;
    int        n_errors;
    int        n;
    logic      seen_b2_clear;
    dr_exp_t   exp_q[$];

    clkmgr_seq_if #(.NUM_DOMAINS(c_NUM_DOMAINS)) bus ();

    clkmgr_seq #(
        .RST_CYCLES   (c_RST_CYCLES),
        .LOCK_STABLE  (c_LOCK_STABLE),
        .LOCK_TIMEOUT (c_LOCK_TIMEOUT),
        .MAX_RETRY    (c_MAX_RETRY),
        .NUM_DOMAINS  (c_NUM_DOMAINS),
        .RELEASE_GAP  (c_RELEASE_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_dr(input logic [4:0] dr, input int gap);
        dr_exp_t e;
        e.dr  = dr;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Full in-order release sequence at the configured gap.
    task automatic push_release_seq();
        push_dr(5'h1E, -1);
        push_dr(5'h1C, c_RELEASE_GAP);
        push_dr(5'h18, c_RELEASE_GAP);
        push_dr(5'h10, c_RELEASE_GAP);
        push_dr(5'h00, c_RELEASE_GAP);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag, output int cnt);
        cnt = 0;
        while (bus.state !== st && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check(tag, bus.state, st);
    endtask

    task automatic wait_dr(input logic [4:0] val, input int budget, input string tag, output int cnt);
        cnt = 0;
        while (bus.domain_reset !== val && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        check(tag, bus.domain_reset, val);
    endtask

    task automatic count_mmcm_high(output int cnt);
        cnt = 0;
        while (bus.mmcm_reset === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Scoreboard: every DOMAIN_RESET change must match the head of the queue.
    task automatic monitor_dr();
        logic [4:0] prev = 5'h1F;
        int         last = 0;
        dr_exp_t    e;
        forever begin
            @(negedge clk);
            if (bus.domain_reset !== prev) begin
                check("dr_change_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("dr_value", bus.domain_reset, e.dr);
                    if (e.gap >= 0) check("dr_gap", cyc - last, e.gap);
                end
                prev = bus.domain_reset;
                last = cyc;
            end
            if (bus.domain_reset[2] === 1'b0) seen_b2_clear = 1'b1;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_mmcm"},  bus.mmcm_reset, 1'b1);
        check({pfx, "_dr"},    bus.domain_reset, 5'h1F);
        check({pfx, "_ready"}, bus.ready, 1'b0);
        check({pfx, "_fail"},  bus.fail, 1'b0);
        check({pfx, "_retry"}, bus.retry_cnt, 8'd0);
        check({pfx, "_loss"},  bus.loss_cnt, 8'd0);
        check({pfx, "_state"}, bus.state, ST_RST);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        seen_b2_clear = 1'b0;
        rst           = 1'b1;
        bus.locked    = 1'b0;
        bus.restart   = 1'b0;
        fork
            monitor_dr();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // 1. Nominal bring-up.
        @(negedge clk);
        rst = 1'b0;
        count_mmcm_high(n);
        check("s1_mmcm_pulse_len", n, c_RST_CYCLES);
        check("s1_state_wait", bus.state, ST_WAIT_LOCK);
        repeat (10) @(negedge clk);
        push_release_seq();
        bus.locked = 1'b1;
        wait_state(ST_RELEASE, 40, "s1_release", n);
        check("s1_lock_latency", n, 2 + c_LOCK_STABLE);
        wait_dr(5'h00, 40, "s1_all_released", n);
        check("s1_ready_before", bus.ready, 1'b0);
        @(negedge clk);
        check("s1_ready", bus.ready, 1'b1);
        check("s1_state_run", bus.state, ST_RUN);
        check("s1_retry", bus.retry_cnt, 8'd0);
        check("s1_queue_empty", exp_q.size(), 0);

        // 4. Lock loss in RUN.
        push_dr(5'h1F, -1);
        bus.locked = 1'b0;
        wait_dr(5'h1F, 5, "s4_dr_reassert", n);
        check("s4_loss_latency_le3", n <= 3, 1'b1);
        check("s4_ready", bus.ready, 1'b0);
        check("s4_loss_cnt", bus.loss_cnt, 8'd1);
        check("s4_state_rst", bus.state, ST_RST);
        count_mmcm_high(n);
        check("s4_mmcm_pulse_len", n, c_RST_CYCLES);

        // 2. Lock glitch during WAIT_LOCK, then 5. loss mid-RELEASE.
        check("s2_state_wait", bus.state, ST_WAIT_LOCK);
        seen_b2_clear = 1'b0;
        bus.locked = 1'b1;
        repeat (5) @(negedge clk);
        bus.locked = 1'b0;
        @(negedge clk);
        bus.locked = 1'b1;
        push_dr(5'h1E, -1);
        push_dr(5'h1C, c_RELEASE_GAP);
        wait_state(ST_RELEASE, 40, "s2_release", n);
        check("s2_lock_latency", n, 2 + c_LOCK_STABLE);
        check("s2_retry", bus.retry_cnt, 8'd0);
        wait_dr(5'h1C, 20, "s5_two_released", n);
        push_dr(5'h1F, -1);
        bus.locked = 1'b0;
        wait_dr(5'h1F, 5, "s5_dr_reassert", n);
        check("s5_loss_cnt", bus.loss_cnt, 8'd2);
        check("s5_state_rst", bus.state, ST_RST);
        check("s5_bit2_never_released", seen_b2_clear, 1'b0);
        check("s5_retry", bus.retry_cnt, 8'd0);

        // 6a. Async reset mid-RELEASE.
        wait_state(ST_WAIT_LOCK, 20, "s6_wait", n);
        push_dr(5'h1E, -1);
        push_dr(5'h1C, c_RELEASE_GAP);
        bus.locked = 1'b1;
        wait_dr(5'h1C, 40, "s6_two_released", n);
        push_dr(5'h1F, -1);
        rst = 1'b1;
        #1;
        check_reset_values("s6_async");
        repeat (2) @(negedge clk);
        push_release_seq();
        rst = 1'b0;
        wait_state(ST_RUN, 80, "s6_run", n);
        check("s6_ready", bus.ready, 1'b1);
        check("s6_loss_after_reset", bus.loss_cnt, 8'd0);

        // 6b. RESTART in the same cycle the lock loss would be acted on.
        push_dr(5'h1F, -1);
        bus.locked = 1'b0;
        repeat (2) @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("s6_restart_state", bus.state, ST_RST);
        check("s6_restart_loss", bus.loss_cnt, 8'd0);
        check("s6_restart_mmcm", bus.mmcm_reset, 1'b1);
        check("s6_restart_ready", bus.ready, 1'b0);

        // 3. Timeout with retries, then FAIL and RESTART.
        for (int i = 0; i <= c_MAX_RETRY; i++) begin
            wait_state(ST_WAIT_LOCK, 20, "s3_wait", n);
            check("s3_retry_cnt", bus.retry_cnt, i);
            check("s3_dr_held", bus.domain_reset, 5'h1F);
            n = 0;
            while (bus.state === ST_WAIT_LOCK && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("s3_wait_len", n, c_LOCK_TIMEOUT);
            if (i < c_MAX_RETRY) begin
                count_mmcm_high(n);
                check("s3_retry_pulse_len", n, c_RST_CYCLES);
            end
        end
        repeat (5) @(negedge clk);
        check("s3_state_fail", bus.state, ST_FAIL);
        check("s3_fail", bus.fail, 1'b1);
        check("s3_mmcm", bus.mmcm_reset, 1'b1);
        check("s3_dr", bus.domain_reset, 5'h1F);
        check("s3_retry_final", bus.retry_cnt, 8'd2);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("s3_restart_state", bus.state, ST_RST);
        check("s3_restart_fail", bus.fail, 1'b0);
        check("s3_restart_retry", bus.retry_cnt, 8'd0);
        check("s3_restart_mmcm", bus.mmcm_reset, 1'b1);

        // RESTART during RST restarts the hold count.
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        count_mmcm_high(n);
        check("rst_restart_pulse_len", n, c_RST_CYCLES);

        repeat (2) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
